mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single processor-memory bus among three requesters: retired stores (from retire), dcache load misses and icache fetch misses.
//  Sits between the retire/cache front ends and the memory controller. Issues one bus command per cycle.
//  Tracks outstanding load tags and routes each memory response back to its owner.
//  Reports bus quiescence so wfi_halt only stops the core after retired stores have drained.
// PARAMETERS
//  MAX_OUTSTANDING  15  max loads in flight (dcache + icache combined); 1..15
//  STARVE_LIMIT     8   consecutive denied cycles before the icache is promoted to top priority
//  XLEN             32  address width
// PORTS
//  clock               in   1     system clock, rising edge
//  reset_n             in   1     asynchronous, active-low reset
//  st_req_valid        in   1     retired store pending
//  st_req_addr         in   XLEN  store address, 8-byte aligned
//  st_req_data         in   64    store data
//  st_req_ready        out  1     store accepted by memory this cycle
//  dc_req_valid        in   1     dcache miss load request
//  dc_req_addr         in   XLEN  dcache miss address
//  dc_req_ready        out  1     dcache load accepted this cycle
//  dc_resp_valid       out  1     dcache load data returning
//  dc_resp_data        out  64    returned data
//  ic_req_valid        in   1     icache miss load request
//  ic_req_addr         in   XLEN  icache miss address
//  ic_req_ready        out  1     icache load accepted this cycle
//  ic_resp_valid       out  1     icache load data returning
//  ic_resp_data        out  64    returned data
//  proc2mem_command    out  2     BUS_NONE / BUS_LOAD / BUS_STORE
//  proc2mem_addr       out  XLEN  bus address
//  proc2mem_data       out  64    store data; 0 when not storing
//  mem2proc_response   in   4     acceptance tag; 0 means the request is rejected
//  mem2proc_data       in   64    response data
//  mem2proc_tag        in   4     tag of the returning data; 0 means none
//  bus_idle            out  1     no store pending and no load outstanding
//  err_bad_tag         out  1     sticky: a response arrived with an unallocated tag
// BEHAVIOUR
//  State
//  - tag table: 16 entries x {valid, owner(DC/IC)}.
//  - outstanding count: 0..15.
//  - icache starve counter: 0..STARVE_LIMIT.
//  - err flag.
//  Reset: all state cleared. Outputs are combinational of state and inputs; with idle inputs they read:
//  - proc2mem_command=BUS_NONE, proc2mem_addr=0, proc2mem_data=0.
//  - all *_ready=0, all *_resp_valid=0, *_resp_data=0.
//  - bus_idle=1, err_bad_tag=0.
//  Arbitration (combinational, same cycle):
//  - Winner order is store > dcache > icache.
//  - If starve counter == STARVE_LIMIT, icache is first.
//  - Loads are ineligible while count == MAX_OUTSTANDING; stores remain eligible.
//  - The winner drives the proc2mem_* outputs.
//  - winner_ready = (mem2proc_response != 0). Losers' ready = 0.
//  - A rejected request (response 0) keeps its valid; it is re-arbitrated next cycle. No state changes.
//  At posedge:
//  - An accepted load sets table[response] = {1, owner} and increments the count.
//  - A store's tag is not recorded.
//  - Starve counter: increments (saturating) when ic_req_valid && !ic_req_ready; clears otherwise.
//  Response routing (combinational):
//  - If mem2proc_tag != 0 and table[tag].valid: assert the owner's resp_valid for 1 cycle with mem2proc_data.
//  - At posedge: clear the entry and decrement the count.
//  - Invalid tag: drop the response and set err_bad_tag (cleared only by reset).
//  Simultaneous events:
//  - Accept and retire in the same cycle leave the count unchanged.
//  - Same tag freed and reallocated in one cycle: route the old owner first, then the new allocation wins the entry.
//  - Accepting a store does not block response routing.
//  bus_idle = !st_req_valid && (count == 0).
//  Reset mid-operation: the table is cleared, so later responses to pre-reset tags raise err_bad_tag.
// TESTING
//  - st, dc and ic valid together, response=3 -> BUS_STORE issued, only st_req_ready=1; dc/ic hold and win on later cycles in order.
//  - dc load, response=5; 4 cycles later tag=5, data=64'hDEAD_BEEF -> dc_resp_valid=1 with that data; count returns to 0; bus_idle=1.
//  - dc_req_valid held constantly with ic_req_valid -> ic wins on cycle 9 (STARVE_LIMIT=8); counter then clears.
//  - Issue 15 loads with no responses -> 16th load ready=0; a store is still accepted; one response frees a slot for the next load.
//  - tag=7 returns while a new load is accepted with response=7 -> old owner gets the data; entry 7 now belongs to the new owner.
//  - Response with tag=9 never allocated -> no resp_valid; err_bad_tag=1 until reset_n is pulsed low.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares the single processor-memory bus between retired
//                stores, dcache load misses and icache fetch misses. One bus
//                command is issued per cycle. Load tags handed back by the
//                memory controller are tracked so that each returning
//                response is routed to the cache that issued the load.
//                bus_idle reports when stores have drained and no load is
//                in flight, so a halting core can stop safely.
//
//  Ports
//    clock, reset_n            : rising-edge clock, async active-low reset
//    st_req_*                  : retired-store request (valid/addr/data/ready)
//    dc_req_*, dc_resp_*       : dcache miss request and returning data
//    ic_req_*, ic_resp_*       : icache miss request and returning data
//    proc2mem_*                : command/address/data driven onto the bus
//    mem2proc_*                : acceptance tag, response data, response tag
//    bus_idle                  : no store pending and no load outstanding
//    err_bad_tag               : sticky, a response carried an unknown tag
//
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 15,  // loads in flight, 1..15
    parameter int STARVE_LIMIT    = 8,   // denied cycles before icache promotion
    parameter int XLEN            = 32   // address width
) (
    input  logic            clock,
    input  logic            reset_n,

    input  logic            st_req_valid,
    input  logic [XLEN-1:0] st_req_addr,
    input  logic [63:0]     st_req_data,
    output logic            st_req_ready,

    input  logic            dc_req_valid,
    input  logic [XLEN-1:0] dc_req_addr,
    output logic            dc_req_ready,
    output logic            dc_resp_valid,
    output logic [63:0]     dc_resp_data,

    input  logic            ic_req_valid,
    input  logic [XLEN-1:0] ic_req_addr,
    output logic            ic_req_ready,
    output logic            ic_resp_valid,
    output logic [63:0]     ic_resp_data,

    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,

    output logic            bus_idle,
    output logic            err_bad_tag
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_bus_none  = 2'd0;
    localparam logic [1:0] c_bus_load  = 2'd1;
    localparam logic [1:0] c_bus_store = 2'd2;

    localparam int c_starve_w = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);
    localparam logic [3:0]            c_max_out    = 4'(MAX_OUTSTANDING);

    // Which requester owns the bus this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ST   = 2'd1,
        GNT_DC   = 2'd2,
        GNT_IC   = 2'd3
    } grant_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]           r_tag_valid;   // tag entry holds an outstanding load
    logic [15:0]           r_tag_owner;   // 1 = icache, 0 = dcache
    logic [3:0]            r_count;       // outstanding loads
    logic [c_starve_w-1:0] r_starve;      // consecutive icache denials
    logic                  r_err;         // sticky bad-tag flag

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    grant_e w_grant;
    logic   w_load_ok;
    logic   w_dc_elig;
    logic   w_ic_elig;
    logic   w_ic_promoted;
    logic   w_mem_accept;

    assign w_load_ok     = (r_count < c_max_out);
    assign w_dc_elig     = dc_req_valid && w_load_ok;
    assign w_ic_elig     = ic_req_valid && w_load_ok;
    assign w_ic_promoted = (r_starve == c_starve_max);
    assign w_mem_accept  = (mem2proc_response != 4'd0);

    always_comb begin
        w_grant = GNT_NONE;
        // A starved icache jumps ahead of stores and dcache for one win;
        // winning clears the starve counter so normal order resumes.
        if (w_ic_promoted && w_ic_elig) begin
            w_grant = GNT_IC;
        end else if (st_req_valid) begin
            w_grant = GNT_ST;
        end else if (w_dc_elig) begin
            w_grant = GNT_DC;
        end else if (w_ic_elig) begin
            w_grant = GNT_IC;
        end
    end

    // The winner drives the bus whether or not memory accepts it; a reject
    // leaves all state untouched and the request simply tries again.
    always_comb begin
        proc2mem_command = c_bus_none;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        st_req_ready     = 1'b0;
        dc_req_ready     = 1'b0;
        ic_req_ready     = 1'b0;
        case (w_grant)
            GNT_ST: begin
                proc2mem_command = c_bus_store;
                proc2mem_addr    = st_req_addr;
                proc2mem_data    = st_req_data;
                st_req_ready     = w_mem_accept;
            end
            GNT_DC: begin
                proc2mem_command = c_bus_load;
                proc2mem_addr    = dc_req_addr;
                dc_req_ready     = w_mem_accept;
            end
            GNT_IC: begin
                proc2mem_command = c_bus_load;
                proc2mem_addr    = ic_req_addr;
                ic_req_ready     = w_mem_accept;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    logic w_tag_present;
    logic w_tag_hit;
    logic w_tag_bad;
    logic w_hit_is_ic;

    // Routing always looks at the table as it was at the start of the
    // cycle, so a tag freed and reallocated in the same cycle still goes
    // to its previous owner.
    assign w_tag_present = (mem2proc_tag != 4'd0);
    assign w_tag_hit     = w_tag_present &&  r_tag_valid[mem2proc_tag];
    assign w_tag_bad     = w_tag_present && !r_tag_valid[mem2proc_tag];
    assign w_hit_is_ic   = r_tag_owner[mem2proc_tag];

    assign dc_resp_valid = w_tag_hit && !w_hit_is_ic;
    assign ic_resp_valid = w_tag_hit &&  w_hit_is_ic;
    assign dc_resp_data  = dc_resp_valid ? mem2proc_data : 64'd0;
    assign ic_resp_data  = ic_resp_valid ? mem2proc_data : 64'd0;

    // ------------------------------------------------------------------
    // Tag table and counter updates
    // ------------------------------------------------------------------
    logic        w_load_accept;
    logic        w_alloc_is_ic;
    logic [15:0] w_alloc_mask;
    logic [15:0] w_free_mask;

    assign w_load_accept = dc_req_ready || ic_req_ready;
    assign w_alloc_is_ic = ic_req_ready;
    assign w_alloc_mask  = w_load_accept ? (16'd1 << mem2proc_response) : 16'd0;
    assign w_free_mask   = w_tag_hit     ? (16'd1 << mem2proc_tag)      : 16'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_valid <= 16'd0;
            r_tag_owner <= 16'd0;
            r_count     <= 4'd0;
        end else begin
            // Clear first, then set: a same-cycle reallocation wins the entry.
            r_tag_valid <= (r_tag_valid & ~w_free_mask) | w_alloc_mask;
            r_tag_owner <= (r_tag_owner & ~w_alloc_mask)
                         | (w_alloc_mask & {16{w_alloc_is_ic}});
            r_count     <= r_count + {3'b000, w_load_accept} - {3'b000, w_tag_hit};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (ic_req_valid && !ic_req_ready) begin
            if (r_starve != c_starve_max) begin
                r_starve <= r_starve + c_starve_w'(1);
            end
        end else begin
            r_starve <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_tag_bad) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    assign bus_idle    = !st_req_valid && (r_count == 4'd0);
    assign err_bad_tag = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Scoreboard bench for mem_bus_arbiter. Stimulus pushes the
//                expected bus/response events; a negedge monitor pops and
//                compares each event the DUT presents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam int SRC_ST  = 0;
    localparam int SRC_DC  = 1;
    localparam int SRC_IC  = 2;
    localparam int SRC_DCR = 3;
    localparam int SRC_ICR = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        st_req_valid, dc_req_valid, ic_req_valid;
    logic [31:0] st_req_addr, dc_req_addr, ic_req_addr;
    logic [63:0] st_req_data;
    logic        st_req_ready, dc_req_ready, ic_req_ready;
    logic        dc_resp_valid, ic_resp_valid;
    logic [63:0] dc_resp_data, ic_resp_data;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic        bus_idle, err_bad_tag;

    always #5 clock = ~clock;

    mem_bus_arbiter #(
        .MAX_OUTSTANDING (15),
        .STARVE_LIMIT    (8),
        .XLEN            (32)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .st_req_valid      (st_req_valid),
        .st_req_addr       (st_req_addr),
        .st_req_data       (st_req_data),
        .st_req_ready      (st_req_ready),
        .dc_req_valid      (dc_req_valid),
        .dc_req_addr       (dc_req_addr),
        .dc_req_ready      (dc_req_ready),
        .dc_resp_valid     (dc_resp_valid),
        .dc_resp_data      (dc_resp_data),
        .ic_req_valid      (ic_req_valid),
        .ic_req_addr       (ic_req_addr),
        .ic_req_ready      (ic_req_ready),
        .ic_resp_valid     (ic_resp_valid),
        .ic_resp_data      (ic_resp_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .bus_idle          (bus_idle),
        .err_bad_tag       (err_bad_tag)
    );

    typedef struct {
        int          src;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int src, input logic [1:0] cmd,
                        input logic [31:0] addr, input logic [63:0] data);
        exp_t e;
        e.src  = src;
        e.cmd  = cmd;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic mon_evt(input int src, input logic [1:0] cmd,
                           input logic [31:0] addr, input logic [63:0] data);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got src=%0d cmd=%0d addr=%0h data=%0h expected none (t=%0t)",
                     src, cmd, addr, data, $time);
        end else begin
            e = sb.pop_front();
            if (e.src != src || e.cmd !== cmd || e.addr !== addr || e.data !== data) begin
                errors++;
                $display("FAIL sb_event: got src=%0d cmd=%0d addr=%0h data=%0h expected src=%0d cmd=%0d addr=%0h data=%0h (t=%0t)",
                         src, cmd, addr, data, e.src, e.cmd, e.addr, e.data, $time);
            end
        end
    endtask

    // Monitor: fixed event order st, dc, ic, dc_resp, ic_resp.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (st_req_ready)  mon_evt(SRC_ST, proc2mem_command, proc2mem_addr, proc2mem_data);
            if (dc_req_ready)  mon_evt(SRC_DC, proc2mem_command, proc2mem_addr, proc2mem_data);
            if (ic_req_ready)  mon_evt(SRC_IC, proc2mem_command, proc2mem_addr, proc2mem_data);
            if (dc_resp_valid) mon_evt(SRC_DCR, 2'd0, 32'd0, dc_resp_data);
            if (ic_resp_valid) mon_evt(SRC_ICR, 2'd0, 32'd0, ic_resp_data);
        end
    end

    // Advance one cycle; every expectation pushed for the cycle must be gone.
    task automatic step();
        @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            chk("sb_drain", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic idle();
        st_req_valid      = 1'b0;
        dc_req_valid      = 1'b0;
        ic_req_valid      = 1'b0;
        mem2proc_response = 4'd0;
        mem2proc_tag      = 4'd0;
        mem2proc_data     = 64'd0;
    endtask

    initial begin
        idle();
        st_req_addr = 32'd0;
        st_req_data = 64'd0;
        dc_req_addr = 32'd0;
        ic_req_addr = 32'd0;
        reset_n     = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_cmd",      64'(proc2mem_command), 64'(BUS_NONE));
        chk("rst_addr",     64'(proc2mem_addr), 64'd0);
        chk("rst_data",     proc2mem_data, 64'd0);
        chk("rst_readies",  64'({st_req_ready, dc_req_ready, ic_req_ready}), 64'd0);
        chk("rst_resp",     64'({dc_resp_valid, ic_resp_valid}), 64'd0);
        chk("rst_resp_dat", dc_resp_data | ic_resp_data, 64'd0);
        chk("rst_idle",     64'(bus_idle), 64'd1);
        chk("rst_err",      64'(err_bad_tag), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // ---------------- priority: store > dcache > icache ----------------
        st_req_valid = 1'b1; dc_req_valid = 1'b1; ic_req_valid = 1'b1;
        st_req_addr = 32'h1000; st_req_data = 64'h1111_2222_3333_4444;
        dc_req_addr = 32'h2000; ic_req_addr = 32'h3000;
        mem2proc_response = 4'd0;
        #2;
        chk("reject_st_ready", 64'(st_req_ready), 64'd0);
        chk("reject_cmd",      64'(proc2mem_command), 64'(BUS_STORE));
        step();
        mem2proc_response = 4'd3;
        push(SRC_ST, BUS_STORE, 32'h1000, 64'h1111_2222_3333_4444);
        #2;
        chk("store_wins_dc", 64'(dc_req_ready), 64'd0);
        chk("store_wins_ic", 64'(ic_req_ready), 64'd0);
        step();
        st_req_valid = 1'b0; mem2proc_response = 4'd4;
        push(SRC_DC, BUS_LOAD, 32'h2000, 64'd0);
        step();
        dc_req_valid = 1'b0; mem2proc_response = 4'd6;
        push(SRC_IC, BUS_LOAD, 32'h3000, 64'd0);
        step();
        ic_req_valid = 1'b0; mem2proc_response = 4'd0;
        mem2proc_tag = 4'd4; mem2proc_data = 64'hA4;
        push(SRC_DCR, 2'd0, 32'd0, 64'hA4);
        #2;
        chk("busy_with_loads", 64'(bus_idle), 64'd0);
        step();
        mem2proc_tag = 4'd6; mem2proc_data = 64'hA6;
        push(SRC_ICR, 2'd0, 32'd0, 64'hA6);
        step();
        idle();
        #2;
        chk("idle_after_t1", 64'(bus_idle), 64'd1);
        step();

        // ---------------- dcache load round trip ----------------
        dc_req_valid = 1'b1; dc_req_addr = 32'h4000; mem2proc_response = 4'd5;
        push(SRC_DC, BUS_LOAD, 32'h4000, 64'd0);
        step();
        idle();
        step();
        #2;
        chk("load_in_flight", 64'(bus_idle), 64'd0);
        step();
        step();
        mem2proc_tag = 4'd5; mem2proc_data = 64'hDEAD_BEEF;
        push(SRC_DCR, 2'd0, 32'd0, 64'hDEAD_BEEF);
        step();
        idle();
        #2;
        chk("idle_after_rt", 64'(bus_idle), 64'd1);
        step();

        // ---------------- icache starvation ----------------
        dc_req_valid = 1'b1; ic_req_valid = 1'b1;
        dc_req_addr = 32'h5000; ic_req_addr = 32'h6000;
        for (int i = 1; i <= 8; i++) begin
            mem2proc_response = 4'(i);
            push(SRC_DC, BUS_LOAD, 32'h5000, 64'd0);
            step();
        end
        mem2proc_response = 4'd9;
        push(SRC_IC, BUS_LOAD, 32'h6000, 64'd0);
        #2;
        chk("starve_promote", 64'(ic_req_ready), 64'd1);
        step();
        mem2proc_response = 4'd10;
        push(SRC_DC, BUS_LOAD, 32'h5000, 64'd0);
        #2;
        chk("starve_cleared", 64'(ic_req_ready), 64'd0);
        step();
        idle();
        for (int t = 1; t <= 10; t++) begin
            mem2proc_tag = 4'(t); mem2proc_data = 64'(t);
            push((t == 9) ? SRC_ICR : SRC_DCR, 2'd0, 32'd0, 64'(t));
            step();
        end
        idle();
        #2;
        chk("idle_after_starve", 64'(bus_idle), 64'd1);
        step();

        // ---------------- outstanding limit ----------------
        dc_req_valid = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            dc_req_addr = 32'h7000 + 32'(8 * i);
            mem2proc_response = 4'(i);
            push(SRC_DC, BUS_LOAD, 32'h7000 + 32'(8 * i), 64'd0);
            step();
        end
        dc_req_addr = 32'h7100; mem2proc_response = 4'd1;
        #2;
        chk("load_full_ready", 64'(dc_req_ready), 64'd0);
        chk("load_full_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
        step();
        st_req_valid = 1'b1; st_req_addr = 32'h9000; st_req_data = 64'h5555;
        mem2proc_response = 4'd2;
        push(SRC_ST, BUS_STORE, 32'h9000, 64'h5555);
        step();
        st_req_valid = 1'b0; mem2proc_response = 4'd3;
        mem2proc_tag = 4'd3; mem2proc_data = 64'h33;
        push(SRC_DCR, 2'd0, 32'd0, 64'h33);
        #2;
        chk("full_same_cycle_free", 64'(dc_req_ready), 64'd0);
        step();
        mem2proc_tag = 4'd0; mem2proc_response = 4'd3;
        push(SRC_DC, BUS_LOAD, 32'h7100, 64'd0);
        step();
        idle();
        for (int t = 1; t <= 15; t++) begin
            mem2proc_tag = 4'(t); mem2proc_data = 64'h100 + 64'(t);
            push(SRC_DCR, 2'd0, 32'd0, 64'h100 + 64'(t));
            step();
        end
        idle();
        #2;
        chk("idle_after_full", 64'(bus_idle), 64'd1);
        step();

        // ---------------- tag freed and reallocated together ----------------
        ic_req_valid = 1'b1; ic_req_addr = 32'h6100; mem2proc_response = 4'd7;
        push(SRC_IC, BUS_LOAD, 32'h6100, 64'd0);
        step();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b1; dc_req_addr = 32'h8000; mem2proc_response = 4'd7;
        mem2proc_tag = 4'd7; mem2proc_data = 64'h77;
        push(SRC_DC, BUS_LOAD, 32'h8000, 64'd0);
        push(SRC_ICR, 2'd0, 32'd0, 64'h77);
        step();
        idle();
        mem2proc_tag = 4'd7; mem2proc_data = 64'h88;
        push(SRC_DCR, 2'd0, 32'd0, 64'h88);
        step();
        idle();
        #2;
        chk("idle_after_realloc", 64'(bus_idle), 64'd1);
        chk("no_err_yet",         64'(err_bad_tag), 64'd0);
        step();

        // ---------------- unallocated tag ----------------
        mem2proc_tag = 4'd9; mem2proc_data = 64'h99;
        #2;
        chk("bad_tag_no_resp", 64'({dc_resp_valid, ic_resp_valid}), 64'd0);
        step();
        idle();
        #2;
        chk("bad_tag_err", 64'(err_bad_tag), 64'd1);
        step();
        step();
        chk("bad_tag_sticky", 64'(err_bad_tag), 64'd1);

        // ---------------- reset mid-operation ----------------
        dc_req_valid = 1'b1; dc_req_addr = 32'hA000; mem2proc_response = 4'd2;
        push(SRC_DC, BUS_LOAD, 32'hA000, 64'd0);
        step();
        idle();
        #2;
        chk("pre_reset_busy", 64'(bus_idle), 64'd0);
        reset_n = 1'b0;
        #1;
        chk("reset_clears_err",   64'(err_bad_tag), 64'd0);
        chk("reset_clears_count", 64'(bus_idle), 64'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mem2proc_tag = 4'd2; mem2proc_data = 64'h22;
        #2;
        chk("stale_tag_dropped", 64'({dc_resp_valid, ic_resp_valid}), 64'd0);
        step();
        idle();
        #2;
        chk("stale_tag_err", 64'(err_bad_tag), 64'd1);
        step();

        chk("sb_empty_at_end", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
